regfile_scoreboard: RTL



---
 rtl/regfile_scoreboard.sv | 110 +++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with two prioritised write ports, write-first read bypass
// and a per-register busy scoreboard used by decode for RAW hazard detection.
module regfile_scoreboard #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG),
   parameter int NRP  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRP*AW-1:0]   rd_addr,
   input  logic [NRP-1:0]      rd_en,
   output logic [NRP*XLEN-1:0] rd_data,
   output logic [NRP-1:0]      rd_busy,
   output logic                hazard,
   input  logic                wr0_en,
   input  logic [AW-1:0]       wr0_addr,
   input  logic [XLEN-1:0]     wr0_data,
   input  logic                wr1_en,
   input  logic [AW-1:0]       wr1_addr,
   input  logic [XLEN-1:0]     wr1_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   output logic [AW:0]         busy_cnt
);

   logic [XLEN-1:0] regs_reg [NREG];
   logic [NREG-1:0] busy_reg;
   logic [NREG-1:0] busy_next;
   logic [AW:0]     busy_cnt_reg;
   logic [AW:0]     busy_cnt_next;

   logic wr0_v, wr1_v, iss_v;
   logic cnt_inc, cnt_dec0, cnt_dec1;

   // Address 0 is hardwired: writes and issue marks to it are dropped here.
   assign wr0_v = wr0_en && (wr0_addr != '0);
   assign wr1_v = wr1_en && (wr1_addr != '0);
   assign iss_v = iss_en && (iss_addr != '0);

   // Port 1 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
      end else begin
         if (wr0_v) regs_reg[wr0_addr] <= wr0_data;
         if (wr1_v) regs_reg[wr1_addr] <= wr1_data;
      end
   end

   // A same-cycle issue beats a writeback clear: a new producer is in flight.
   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_busy
         logic set_hit, clr_hit;
         assign set_hit = iss_v && (iss_addr == AW'(gi));
         assign clr_hit = (wr0_v && (wr0_addr == AW'(gi))) || (wr1_v && (wr1_addr == AW'(gi)));
         assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_reg <= '0;
      else        busy_reg <= busy_next;
   end

   // Incremental popcount; port 1 does not decrement again when both ports hit one register.
   always_comb begin
      cnt_inc  = iss_v && !busy_reg[iss_addr];
      cnt_dec0 = wr0_v && busy_reg[wr0_addr] && !(iss_v && (iss_addr == wr0_addr));
      cnt_dec1 = wr1_v && busy_reg[wr1_addr] && !(iss_v && (iss_addr == wr1_addr))
                 && !(wr0_v && (wr0_addr == wr1_addr));
      busy_cnt_next = busy_cnt_reg + {{AW{1'b0}}, cnt_inc}
                                   - {{AW{1'b0}}, cnt_dec0}
                                   - {{AW{1'b0}}, cnt_dec1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_cnt_reg <= '0;
      else        busy_cnt_reg <= busy_cnt_next;
   end

   assign busy_cnt = busy_cnt_reg;

   generate
      for (gi = 0; gi < NRP; gi++) begin : g_rd
         logic [AW-1:0]   ra;
         logic            hit0, hit1;
         logic [XLEN-1:0] rdata;

         assign ra   = rd_addr[gi*AW +: AW];
         assign hit0 = wr0_v && (wr0_addr == ra);
         assign hit1 = wr1_v && (wr1_addr == ra);

         // Outputs are forced quiet while reset is held, even with bypass traffic present.
         always_comb begin
            rdata = regs_reg[ra];
            if (hit0) rdata = wr0_data;
            if (hit1) rdata = wr1_data;
            if (!rst_n || (ra == '0)) rdata = '0;
         end

         assign rd_data[gi*XLEN +: XLEN] = rdata;
         assign rd_busy[gi] = rst_n & busy_reg[ra] & ~hit0 & ~hit1;
      end
   endgenerate

   assign hazard = |(rd_en & rd_busy);

endmodule
